// File: rtl/store_narrow_buffer.sv
// rtl/store_narrow_buffer.sv - store formatting FIFO (sb/sh/sw -> lane-replicated data + byte enables)
// Optional alignment drop enabled by defining STORE_ALIGN_CHECK_EN.
module store_narrow_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_data,
  input  logic [1:0]       req_size,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  output logic [CNT_W-1:0] count,
  output logic             misalign
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      addr_mem  [DEPTH];
  logic [31:0]      wdata_mem [DEPTH];
  logic [3:0]       be_mem    [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occ;

  logic             full;
  logic             empty;
  logic             accept;
  logic             pop;
  logic             push;
  logic             drop;
  logic [31:0]      fmt_wdata;
  logic [3:0]       fmt_be;

  assign full      = (occ == FULL_CNT);
  assign empty     = (occ == '0);
  assign req_ready = !full;
  assign mem_valid = !empty;
  assign count     = occ;

  assign accept = req_valid && !full;
  assign pop    = !empty && mem_ready;
  assign push   = accept && !drop;

  // Data is replicated across lanes so memory only needs the byte enables.
  always_comb begin
    fmt_wdata = req_data;
    fmt_be    = 4'b1111;
    case (req_size)
      2'b00: begin
        fmt_wdata = {4{req_data[7:0]}};
        fmt_be    = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        fmt_wdata = {2{req_data[15:0]}};
        fmt_be    = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        fmt_wdata = req_data;
        fmt_be    = 4'b1111;
      end
    endcase
  end

`ifdef STORE_ALIGN_CHECK_EN
  logic misaligned_req;
  logic misalign_q;

  always_comb begin
    misaligned_req = 1'b0;
    case (req_size)
      2'b00:   misaligned_req = 1'b0;
      2'b01:   misaligned_req = req_addr[0];
      default: misaligned_req = |req_addr[1:0];
    endcase
  end

  assign drop = accept && misaligned_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= drop;
    end
  end

  assign misalign = misalign_q;
`else
  assign drop     = 1'b0;
  assign misalign = 1'b0;
`endif

  // Storage is cleared on reset so the head outputs read as zero immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i]  <= '0;
        wdata_mem[i] <= '0;
        be_mem[i]    <= '0;
      end
    end else if (push) begin
      addr_mem[wr_ptr]  <= {req_addr[31:2], 2'b00};
      wdata_mem[wr_ptr] <= fmt_wdata;
      be_mem[wr_ptr]    <= fmt_be;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign mem_addr  = addr_mem[rd_ptr];
  assign mem_wdata = wdata_mem[rd_ptr];
  assign mem_be    = be_mem[rd_ptr];

endmodule
